// File: rtl/hazard_forward_ctrl.sv
// Forwarding/hazard control beside the D/E register: tracks E and M slot tags, raises the
// load-use stall and flush bubble, and registers the forwarding mux selects one stage ahead.
module hazard_forward_ctrl #(
  parameter int unsigned REG_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_stall,
  input  logic                flush,
  input  logic                d_valid,
  input  logic [REG_BITS-1:0] d_rs,
  input  logic [REG_BITS-1:0] d_rt,
  input  logic                d_rs_used,
  input  logic                d_rt_used,
  input  logic                d_is_store,
  input  logic                d_wr_en,
  input  logic [REG_BITS-1:0] d_rd,
  input  logic                d_mem_read,
  output logic [1:0]          ex_ex_forwarding,
  output logic [1:0]          ex_mem_forwarding,
  output logic                mem_mem_forwarding,
  output logic                stall_fd,
  output logic                bubble_de
);

  // E slot tags
  logic                e_valid_q, e_valid_d;
  logic                e_wr_en_q, e_wr_en_d;
  logic [REG_BITS-1:0] e_rd_q, e_rd_d;
  logic                e_mem_read_q, e_mem_read_d;
  logic [REG_BITS-1:0] e_rt_q, e_rt_d;
  logic                e_is_store_q, e_is_store_d;

  // M slot tags. The W slot needs no storage: every select that depends on it is
  // computed from M one edge earlier and registered.
  logic                m_valid_q, m_valid_d;
  logic                m_wr_en_q, m_wr_en_d;
  logic [REG_BITS-1:0] m_rd_q, m_rd_d;
  logic                m_mem_read_q, m_mem_read_d;

  logic [1:0]          ex_ex_q, ex_ex_d;
  logic [1:0]          ex_mem_q, ex_mem_d;
  logic                mem_mem_q, mem_mem_d;

  logic                hazard;
  logic                enter;
  logic [1:0]          src_used;

  function automatic logic tag_match(input logic                valid,
                                     input logic                wr_en,
                                     input logic [REG_BITS-1:0] rd,
                                     input logic [REG_BITS-1:0] src);
    return valid & wr_en & (rd == src) & (rd != '0);
  endfunction

  // Store data (rt) is consumed in MEM, so a load feeding it is covered by mem_mem.
  always_comb begin
    hazard = d_valid & ~flush & e_mem_read_q &
             ((d_rs_used & tag_match(e_valid_q, e_wr_en_q, e_rd_q, d_rs)) |
              (d_rt_used & ~d_is_store & tag_match(e_valid_q, e_wr_en_q, e_rd_q, d_rt)));
    stall_fd  = hazard;
    bubble_de = hazard | flush;
    enter     = d_valid & ~flush & ~hazard;
    src_used  = {d_rt_used | d_is_store, d_rs_used};
  end

  always_comb begin
    ex_ex_d[0]  = enter & src_used[0] & ~e_mem_read_q &
                  tag_match(e_valid_q, e_wr_en_q, e_rd_q, d_rs);
    ex_ex_d[1]  = enter & src_used[1] & ~e_mem_read_q &
                  tag_match(e_valid_q, e_wr_en_q, e_rd_q, d_rt);
    // Younger producer in E takes priority over M.
    ex_mem_d[0] = enter & src_used[0] & ~ex_ex_d[0] &
                  tag_match(m_valid_q, m_wr_en_q, m_rd_q, d_rs);
    ex_mem_d[1] = enter & src_used[1] & ~ex_ex_d[1] &
                  tag_match(m_valid_q, m_wr_en_q, m_rd_q, d_rt);
    mem_mem_d   = e_valid_q & e_is_store_q & m_mem_read_q &
                  tag_match(m_valid_q, m_wr_en_q, m_rd_q, e_rt_q);
  end

  always_comb begin
    e_valid_d    = d_valid & ~bubble_de;
    e_wr_en_d    = d_wr_en;
    e_rd_d       = d_rd;
    e_mem_read_d = d_mem_read;
    e_rt_d       = d_rt;
    e_is_store_d = d_is_store;
    m_valid_d    = e_valid_q;
    m_wr_en_d    = e_wr_en_q;
    m_rd_d       = e_rd_q;
    m_mem_read_d = e_mem_read_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid_q    <= 1'b0;
      e_wr_en_q    <= 1'b0;
      e_rd_q       <= '0;
      e_mem_read_q <= 1'b0;
      e_rt_q       <= '0;
      e_is_store_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_wr_en_q    <= 1'b0;
      m_rd_q       <= '0;
      m_mem_read_q <= 1'b0;
      ex_ex_q      <= 2'b00;
      ex_mem_q     <= 2'b00;
      mem_mem_q    <= 1'b0;
    end else if (!mem_stall) begin
      e_valid_q    <= e_valid_d;
      e_wr_en_q    <= e_wr_en_d;
      e_rd_q       <= e_rd_d;
      e_mem_read_q <= e_mem_read_d;
      e_rt_q       <= e_rt_d;
      e_is_store_q <= e_is_store_d;
      m_valid_q    <= m_valid_d;
      m_wr_en_q    <= m_wr_en_d;
      m_rd_q       <= m_rd_d;
      m_mem_read_q <= m_mem_read_d;
      ex_ex_q      <= ex_ex_d;
      ex_mem_q     <= ex_mem_d;
      mem_mem_q    <= mem_mem_d;
    end
  end

  assign ex_ex_forwarding   = ex_ex_q;
  assign ex_mem_forwarding  = ex_mem_q;
  assign mem_mem_forwarding = mem_mem_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed pipeline scenarios plus randomized traffic
// checked against an instruction-level pipeline model.
module tb_hazard_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst, mem_stall, flush, d_valid;
  logic [3:0] d_rs, d_rt, d_rd;
  logic       d_rs_used, d_rt_used, d_is_store, d_wr_en, d_mem_read;
  logic [1:0] ex_ex_forwarding, ex_mem_forwarding;
  logic       mem_mem_forwarding, stall_fd, bubble_de;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.REG_BITS(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_stall          (mem_stall),
    .flush              (flush),
    .d_valid            (d_valid),
    .d_rs               (d_rs),
    .d_rt               (d_rt),
    .d_rs_used          (d_rs_used),
    .d_rt_used          (d_rt_used),
    .d_is_store         (d_is_store),
    .d_wr_en            (d_wr_en),
    .d_rd               (d_rd),
    .d_mem_read         (d_mem_read),
    .ex_ex_forwarding   (ex_ex_forwarding),
    .ex_mem_forwarding  (ex_mem_forwarding),
    .mem_mem_forwarding (mem_mem_forwarding),
    .stall_fd           (stall_fd),
    .bubble_de          (bubble_de)
  );

  typedef struct packed {
    logic       v;
    logic       we;
    logic [3:0] rd;
    logic       ld;
    logic [3:0] rt;
    logic       st;
  } ins_t;

  // pipe[0] is the instruction in EX, pipe[1] the one in MEM
  ins_t       pipe [2];
  logic [1:0] m_exex = 2'b00, m_exmem = 2'b00;
  logic       m_mm = 1'b0;
  int         checks = 0, errors = 0;

  function automatic logic writes(input ins_t s, input logic [3:0] r);
    return s.v && s.we && (s.rd == r) && (r != 4'd0);
  endfunction

  function automatic logic model_hazard();
    if (!d_valid || flush || !pipe[0].ld) return 1'b0;
    return (d_rs_used && writes(pipe[0], d_rs)) ||
           (d_rt_used && !d_is_store && writes(pipe[0], d_rt));
  endfunction

  task automatic set_ins(input logic v, input logic [3:0] rs, input logic rs_u,
                         input logic [3:0] rt, input logic rt_u, input logic st,
                         input logic we, input logic [3:0] rd, input logic ld);
    d_valid = v; d_rs = rs; d_rs_used = rs_u; d_rt = rt; d_rt_used = rt_u;
    d_is_store = st; d_wr_en = we; d_rd = rd; d_mem_read = ld;
  endtask

  task automatic set_nop();
    set_ins(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  // One clock edge; the model advances from the inputs held across that edge.
  task automatic cycle();
    ins_t       d;
    logic       go, r, s;
    logic [1:0] nxe, nxm;
    logic       nmm;
    logic [3:0] src;
    logic       use_i;
    d.v = d_valid; d.we = d_wr_en; d.rd = d_rd; d.ld = d_mem_read; d.rt = d_rt; d.st = d_is_store;
    go = d_valid && !flush && !model_hazard();
    for (int i = 0; i < 2; i++) begin
      src   = (i == 0) ? d_rs : d_rt;
      use_i = (i == 0) ? d_rs_used : (d_rt_used || d_is_store);
      nxe[i] = go && use_i && writes(pipe[0], src) && !pipe[0].ld;
      nxm[i] = go && use_i && writes(pipe[1], src) && !nxe[i];
    end
    nmm = pipe[0].v && pipe[0].st && pipe[1].ld && writes(pipe[1], pipe[0].rt);
    r = rst;
    s = mem_stall;
    @(posedge clk);
    #1;
    if (r) begin
      pipe[0] = '0; pipe[1] = '0; m_exex = 2'b00; m_exmem = 2'b00; m_mm = 1'b0;
    end else if (!s) begin
      pipe[1] = pipe[0];
      pipe[0] = go ? d : '0;
      m_exex = nxe; m_exmem = nxm; m_mm = nmm;
    end
  endtask

  task automatic idle(input int n);
    set_nop();
    repeat (n) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_stall = 1'b0; flush = 1'b0;
    set_nop();
    cycle(); cycle();
    checks++;
    if ({ex_ex_forwarding, ex_mem_forwarding, mem_mem_forwarding} !== 5'b0) begin
      errors++;
      $display("FAIL reset_fwd: got %b %b %b want 00 00 0",
               ex_ex_forwarding, ex_mem_forwarding, mem_mem_forwarding);
    end
    checks++;
    if ({stall_fd, bubble_de} !== 2'b00) begin
      errors++; $display("FAIL reset_stall: got %b%b want 00", stall_fd, bubble_de);
    end
    rst = 1'b0;
  endtask

  task automatic test_ex_ex();
    idle(3);
    set_ins(1, 4'd2, 1, 4'd3, 1, 0, 1, 4'd1, 0);   // ADD R1
    cycle();
    set_ins(1, 4'd1, 1, 4'd4, 1, 0, 1, 4'd5, 0);   // ADD rs=R1
    #1;
    checks++;
    if (stall_fd !== 1'b0) begin errors++; $display("FAIL exex_nostall: got %b want 0", stall_fd); end
    cycle();
    checks++;
    if (ex_ex_forwarding !== 2'b01 || ex_mem_forwarding !== 2'b00) begin
      errors++; $display("FAIL exex_rs: got ex_ex=%b ex_mem=%b want 01 00",
                         ex_ex_forwarding, ex_mem_forwarding);
    end
  endtask

  task automatic test_ex_mem();
    idle(3);
    set_ins(1, 4'd3, 1, 4'd4, 1, 0, 1, 4'd2, 0);   // ADD R2
    cycle();
    set_nop();
    cycle();
    set_ins(1, 4'd5, 1, 4'd2, 1, 0, 1, 4'd6, 0);   // SUB rt=R2
    cycle();
    checks++;
    if (ex_mem_forwarding !== 2'b10 || ex_ex_forwarding !== 2'b00) begin
      errors++; $display("FAIL exmem_rt: got ex_ex=%b ex_mem=%b want 00 10",
                         ex_ex_forwarding, ex_mem_forwarding);
    end
  endtask

  task automatic test_load_use();
    idle(3);
    set_ins(1, 4'd6, 1, 4'd0, 0, 0, 1, 4'd3, 1);   // LW R3
    cycle();
    set_ins(1, 4'd3, 1, 4'd7, 1, 0, 1, 4'd8, 0);   // ADD rs=R3
    #1;
    checks++;
    if ({stall_fd, bubble_de} !== 2'b11) begin
      errors++; $display("FAIL lu_stall: got %b%b want 11", stall_fd, bubble_de);
    end
    cycle();
    checks++;
    if ({stall_fd, bubble_de, ex_ex_forwarding, ex_mem_forwarding} !== 6'b0) begin
      errors++; $display("FAIL lu_bubble: got stall=%b bub=%b ex_ex=%b ex_mem=%b want all 0",
                         stall_fd, bubble_de, ex_ex_forwarding, ex_mem_forwarding);
    end
    cycle();
    checks++;
    if (ex_mem_forwarding !== 2'b01 || ex_ex_forwarding !== 2'b00) begin
      errors++; $display("FAIL lu_fwd: got ex_ex=%b ex_mem=%b want 00 01",
                         ex_ex_forwarding, ex_mem_forwarding);
    end
  endtask

  task automatic test_load_store();
    idle(3);
    set_ins(1, 4'd6, 1, 4'd0, 0, 0, 1, 4'd4, 1);   // LW R4
    cycle();
    set_ins(1, 4'd7, 1, 4'd4, 0, 1, 0, 4'd0, 0);   // SW rt=R4
    #1;
    checks++;
    if (stall_fd !== 1'b0) begin errors++; $display("FAIL ls_nostall: got %b want 0", stall_fd); end
    cycle();
    checks++;
    if (ex_ex_forwarding !== 2'b00 || mem_mem_forwarding !== 1'b0) begin
      errors++; $display("FAIL ls_ex: got ex_ex=%b mm=%b want 00 0",
                         ex_ex_forwarding, mem_mem_forwarding);
    end
    set_nop();
    cycle();
    checks++;
    if (mem_mem_forwarding !== 1'b1) begin
      errors++; $display("FAIL ls_memmem: got %b want 1", mem_mem_forwarding);
    end
  endtask

  task automatic test_r0();
    idle(3);
    set_ins(1, 4'd1, 1, 4'd2, 1, 0, 1, 4'd0, 0);   // ADD R0
    cycle();
    set_ins(1, 4'd0, 1, 4'd0, 1, 0, 1, 4'd9, 0);   // ADD rs=R0 rt=R0
    cycle();
    checks++;
    if (ex_ex_forwarding !== 2'b00 || ex_mem_forwarding !== 2'b00) begin
      errors++; $display("FAIL r0_e: got ex_ex=%b ex_mem=%b want 00 00",
                         ex_ex_forwarding, ex_mem_forwarding);
    end
    cycle();
    checks++;
    if (ex_mem_forwarding !== 2'b00) begin
      errors++; $display("FAIL r0_m: got ex_mem=%b want 00", ex_mem_forwarding);
    end
  endtask

  task automatic test_flush();
    idle(3);
    set_ins(1, 4'd6, 1, 4'd0, 0, 0, 1, 4'd5, 1);   // LW R5
    cycle();
    set_ins(1, 4'd5, 1, 4'd0, 0, 0, 1, 4'd10, 0);  // ADD rs=R5, flushed
    flush = 1'b1;
    #1;
    checks++;
    if ({stall_fd, bubble_de} !== 2'b01) begin
      errors++; $display("FAIL flush_pri: got %b%b want 01", stall_fd, bubble_de);
    end
    cycle();
    flush = 1'b0;
    checks++;
    if (ex_ex_forwarding !== 2'b00 || ex_mem_forwarding !== 2'b00) begin
      errors++; $display("FAIL flush_kill: got ex_ex=%b ex_mem=%b want 00 00",
                         ex_ex_forwarding, ex_mem_forwarding);
    end
    cycle();
    checks++;
    if (ex_mem_forwarding !== 2'b01) begin
      errors++; $display("FAIL flush_refetch: got ex_mem=%b want 01", ex_mem_forwarding);
    end
  endtask

  task automatic test_mem_stall();
    idle(3);
    set_ins(1, 4'd2, 1, 4'd3, 1, 0, 1, 4'd1, 0);   // ADD R1
    cycle();
    set_ins(1, 4'd1, 1, 4'd2, 1, 0, 1, 4'd8, 0);   // ADD R8 <- R1
    cycle();
    mem_stall = 1'b1;
    set_ins(1, 4'd9, 1, 4'd10, 1, 0, 1, 4'd11, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (ex_ex_forwarding !== 2'b01 || ex_mem_forwarding !== 2'b00) begin
        errors++; $display("FAIL stall_hold%0d: got ex_ex=%b ex_mem=%b want 01 00",
                           i, ex_ex_forwarding, ex_mem_forwarding);
      end
    end
    mem_stall = 1'b0;
    set_ins(1, 4'd1, 1, 4'd8, 1, 0, 1, 4'd12, 0);  // reads R1 (in M) and R8 (in E)
    cycle();
    checks++;
    if (ex_ex_forwarding !== 2'b10 || ex_mem_forwarding !== 2'b01) begin
      errors++; $display("FAIL stall_resume: got ex_ex=%b ex_mem=%b want 10 01",
                         ex_ex_forwarding, ex_mem_forwarding);
    end
  endtask

  task automatic test_reset_mid_hazard();
    idle(3);
    set_ins(1, 4'd2, 1, 4'd3, 1, 0, 1, 4'd1, 0);   // ADD R1
    cycle();
    set_ins(1, 4'd1, 1, 4'd0, 0, 0, 1, 4'd3, 1);   // LW R3 base R1
    cycle();
    set_ins(1, 4'd3, 1, 4'd0, 0, 0, 1, 4'd4, 0);   // ADD rs=R3
    #1;
    checks++;
    if (ex_ex_forwarding !== 2'b01 || stall_fd !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: got ex_ex=%b stall=%b want 01 1",
                         ex_ex_forwarding, stall_fd);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if ({ex_ex_forwarding, ex_mem_forwarding, mem_mem_forwarding, stall_fd, bubble_de} !== 7'b0)
    begin
      errors++; $display("FAIL rstmid_post: got %b %b %b %b %b want all 0", ex_ex_forwarding,
                         ex_mem_forwarding, mem_mem_forwarding, stall_fd, bubble_de);
    end
  endtask

  task automatic test_random(input int n);
    logic e_st, e_bb;
    for (int k = 0; k < n; k++) begin
      rst       = ($urandom_range(0, 99) < 2);
      mem_stall = ($urandom_range(0, 99) < 15);
      flush     = ($urandom_range(0, 99) < 10);
      set_ins(($urandom_range(0, 99) < 80), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 20),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), ($urandom_range(0, 99) < 35));
      #1;
      e_st = model_hazard();
      e_bb = e_st || flush;
      checks++;
      if (stall_fd !== e_st || bubble_de !== e_bb) begin
        errors++; $display("FAIL rnd_stall[%0d]: got %b%b want %b%b", k, stall_fd, bubble_de,
                           e_st, e_bb);
      end
      cycle();
      checks++;
      if (ex_ex_forwarding !== m_exex || ex_mem_forwarding !== m_exmem ||
          mem_mem_forwarding !== m_mm) begin
        errors++; $display("FAIL rnd_fwd[%0d]: got %b %b %b want %b %b %b", k, ex_ex_forwarding,
                           ex_mem_forwarding, mem_mem_forwarding, m_exex, m_exmem, m_mm);
      end
      checks++;
      if ((ex_ex_forwarding & ex_mem_forwarding) !== 2'b00) begin
        errors++; $display("FAIL rnd_pair[%0d]: got ex_ex=%b ex_mem=%b want disjoint", k,
                           ex_ex_forwarding, ex_mem_forwarding);
      end
    end
    rst = 1'b0; mem_stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    pipe[0] = '0;
    pipe[1] = '0;
    rst = 1'b1; mem_stall = 1'b0; flush = 1'b0;
    set_nop();
    test_reset();
    test_ex_ex();
    test_ex_mem();
    test_load_use();
    test_load_store();
    test_r0();
    test_flush();
    test_mem_stall();
    test_reset_mid_hazard();
    test_random(600);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
